// File: rtl/calc_k_and_error.sv
// One Levinson-Durbin step in single precision: k = -alpha/E and E' = E*(1-k^2).
// Every operation truncates toward zero. Subnormal inputs count as zero, underflow flushes to +0, and overflow saturates.
module calc_k_and_error (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic [31:0] iAlpham,
  input  logic [31:0] iErrorm,
  output logic [31:0] oKmp1,
  output logic [31:0] oErrormp1,
  output logic        oDone
);

  localparam int unsigned FP_W      = 32;
  localparam int unsigned MANT_W    = 24;
  localparam int unsigned DIV_STEPS = 25;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ALIGN_W   = 51;
  localparam int unsigned GUARD_W   = 27;
  localparam int unsigned EXP_W     = 11;

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    PACK_K,
    SQUARE,
    SUB,
    MUL_E,
    DONE
  } state_t;

  state_t state, state_n;

  logic [FP_W-1:0]    alpha_q, err_q, k_q, om_q;
  logic [FP_W-2:0]    sq_q;
  logic [MANT_W:0]    rem_q, quo_q;
  logic [CNT_W-1:0]   cnt_q;

  // Significand with hidden bit; exponent field 0 reads as zero.
  function automatic logic [MANT_W-1:0] mant_of(input logic [FP_W-1:0] f);
    mant_of = (f[30:23] == 8'h00) ? '0 : {1'b1, f[22:0]};
  endfunction

  function automatic logic is_zero(input logic [FP_W-1:0] f);
    is_zero = (f[30:23] == 8'h00);
  endfunction

  function automatic logic signed [EXP_W-1:0] exp_of(input logic [FP_W-1:0] f);
    exp_of = $signed({3'b000, f[30:23]});
  endfunction

  // Assemble a result, flushing underflow or a zero significand and saturating overflow.
  function automatic logic [FP_W-1:0] pack_fp(input logic                    s,
                                              input logic signed [EXP_W-1:0] ex,
                                              input logic [MANT_W-1:0]       m);
    if (ex <= 11'sd0 || !m[MANT_W-1])
      pack_fp = '0;
    else if (ex >= 11'sd255)
      pack_fp = {s, 31'h7F7F_FFFF};
    else
      pack_fp = {s, ex[7:0], m[22:0]};
  endfunction

  function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a,
                                             input logic [FP_W-1:0] b);
    logic [2*MANT_W-1:0]    p;
    logic signed [EXP_W-1:0] ex;
    logic [MANT_W-1:0]      m;
    p  = (2*MANT_W)'(mant_of(a)) * (2*MANT_W)'(mant_of(b));
    ex = exp_of(a) + exp_of(b) - 11'sd127;
    if (p[2*MANT_W-1]) begin
      m  = MANT_W'(p >> MANT_W);
      ex = ex + 11'sd1;
    end else begin
      m  = MANT_W'(p >> (MANT_W-1));
    end
    if (is_zero(a) || is_zero(b))
      fp_mul = '0;
    else
      fp_mul = pack_fp(a[31] ^ b[31], ex, m);
  endfunction

  function automatic logic [5:0] lead_one(input logic [ALIGN_W-1:0] v);
    lead_one = '0;
    for (int i = 0; i < ALIGN_W; i++)
      if (v[i]) lead_one = 6'(i);
  endfunction

  // State register
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset)
      state <= IDLE;
    else if (iEnable)
      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = DIV;
      DIV:     if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_n = PACK_K;
      PACK_K:  state_n = SQUARE;
      SQUARE:  state_n = SUB;
      SUB:     state_n = MUL_E;
      MUL_E:   state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // One restoring-divide step
  logic              rem_ge_c;
  logic [MANT_W:0]   rem_sub_c, rem_nxt_c;
  always_comb begin
    rem_ge_c  = (rem_q >= {1'b0, mant_of(err_q)});
    rem_sub_c = rem_ge_c ? (rem_q - {1'b0, mant_of(err_q)}) : rem_q;
    rem_nxt_c = rem_sub_c << 1;
  end

  // Quotient normalization into k
  logic signed [EXP_W-1:0] k_ex_c;
  logic [MANT_W-1:0]       k_m_c;
  logic [FP_W-1:0]         k_c;
  always_comb begin
    k_ex_c = exp_of(alpha_q) - exp_of(err_q) + 11'sd127;
    if (quo_q[MANT_W]) begin
      k_m_c = quo_q[MANT_W:1];
    end else begin
      k_m_c  = quo_q[MANT_W-1:0];
      k_ex_c = k_ex_c - 11'sd1;
    end
    if (is_zero(alpha_q) || is_zero(err_q))
      k_c = '0;
    else
      k_c = pack_fp(~(alpha_q[31] ^ err_q[31]), k_ex_c, k_m_c);
  end

  // 1 - k^2: align exactly, fold the shifted-out bits into a borrow so the result truncates
  logic [MANT_W-1:0]       sq_m_c, big_m_c, small_m_c;
  logic [7:0]              sq_e_c, big_e_c, shamt_c;
  logic                    sq_big_c, om_s_c, sticky_c;
  logic [ALIGN_W-1:0]      small_full_c, small_al_c, small_back_c, diff_c, norm_c;
  logic [5:0]              lead_c, nsh_c;
  logic signed [EXP_W-1:0] om_ex_c;
  logic [FP_W-1:0]         om_c;
  always_comb begin
    sq_m_c   = mant_of({1'b0, sq_q});
    sq_e_c   = sq_q[30:23];
    sq_big_c = (sq_e_c > 8'd127) || (sq_e_c == 8'd127 && sq_m_c > 24'h80_0000);
    if (sq_big_c) begin
      big_m_c   = sq_m_c;
      big_e_c   = sq_e_c;
      small_m_c = 24'h80_0000;
      shamt_c   = sq_e_c - 8'd127;
      om_s_c    = 1'b1;
    end else begin
      big_m_c   = 24'h80_0000;
      big_e_c   = 8'd127;
      small_m_c = sq_m_c;
      shamt_c   = 8'd127 - sq_e_c;
      om_s_c    = 1'b0;
    end
    small_full_c = {small_m_c, {GUARD_W{1'b0}}};
    small_al_c   = small_full_c >> shamt_c;
    small_back_c = small_al_c << shamt_c;
    sticky_c     = (small_back_c != small_full_c);
    diff_c       = {big_m_c, {GUARD_W{1'b0}}} - small_al_c - ALIGN_W'(sticky_c);
    lead_c       = lead_one(diff_c);
    nsh_c        = 6'(ALIGN_W - 1) - lead_c;
    norm_c       = diff_c << nsh_c;
    om_ex_c      = $signed({3'b000, big_e_c}) - $signed({5'b00000, nsh_c});
    om_c         = pack_fp(om_s_c, om_ex_c, MANT_W'(norm_c >> GUARD_W));
  end

  // Datapath and result registers
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      alpha_q   <= '0;
      err_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      sq_q      <= '0;
      om_q      <= '0;
      oKmp1     <= '0;
      oErrormp1 <= '0;
      oDone     <= 1'b0;
    end else if (iEnable) begin
      case (state)
        IDLE: begin
          alpha_q <= iAlpham;
          err_q   <= iErrorm;
          rem_q   <= {1'b0, mant_of(iAlpham)};
          quo_q   <= '0;
          cnt_q   <= '0;
        end
        DIV: begin
          quo_q <= {quo_q[MANT_W-1:0], rem_ge_c};
          rem_q <= rem_nxt_c;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        PACK_K: k_q  <= k_c;
        SQUARE: sq_q <= (FP_W-1)'(fp_mul(k_q, k_q));
        SUB:    om_q <= om_c;
        MUL_E: begin
          oKmp1     <= k_q;
          oErrormp1 <= fp_mul(err_q, om_q);
          oDone     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_k_and_error.sv
// Directed bench for calc_k_and_error: reset, result vectors, enable stalls, abort and hold.
module tb_calc_k_and_error;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iEnable = 1'b0;
  logic [31:0] iAlpham = '0;
  logic [31:0] iErrorm = '0;
  logic [31:0] oKmp1;
  logic [31:0] oErrormp1;
  logic        oDone;

  int checks = 0;
  int failures = 0;

  calc_k_and_error dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iEnable   (iEnable),
    .iAlpham   (iAlpham),
    .iErrorm   (iErrorm),
    .oKmp1     (oKmp1),
    .oErrormp1 (oErrormp1),
    .oDone     (oDone)
  );

  always #5 iClock = ~iClock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset, apply inputs, release on a falling edge; the next rising edge captures.
  task automatic start_run(input logic [31:0] a, input logic [31:0] e);
    @(negedge iClock);
    iReset  = 1'b0;
    iEnable = 1'b1;
    iAlpham = a;
    iErrorm = e;
    @(negedge iClock);
    iReset = 1'b1;
  endtask

  // Count rising edges (capture edge is 1) until oDone, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge iClock);
      #1;
      n++;
      if (oDone) break;
    end
  endtask

  task automatic test_reset();
    iReset  = 1'b0;
    iEnable = 1'b1;
    iAlpham = 32'hBF00_0000;
    iErrorm = 32'h3F80_0000;
    repeat (3) @(posedge iClock);
    #1;
    checks++;
    if (oKmp1 !== 32'h0) begin failures++; $display("FAIL reset_k: got %h expected %h", oKmp1, 32'h0); end
    checks++;
    if (oErrormp1 !== 32'h0) begin failures++; $display("FAIL reset_e: got %h expected %h", oErrormp1, 32'h0); end
    checks++;
    if (oDone !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", oDone); end
  endtask

  task automatic test_basic();
    start_run(32'hBF00_0000, 32'h3F80_0000);
    for (int i = 1; i <= 29; i++) begin
      @(posedge iClock);
      #1;
      checks++;
      if (oDone !== 1'b0 || oKmp1 !== 32'h0 || oErrormp1 !== 32'h0) begin
        failures++;
        $display("FAIL basic_early edge %0d: got done=%b k=%h e=%h expected 0/0/0", i, oDone, oKmp1, oErrormp1);
      end
    end
    @(posedge iClock);
    #1;
    checks++;
    if (oDone !== 1'b1) begin failures++; $display("FAIL basic_done: got %b expected 1", oDone); end
    checks++;
    if (oKmp1 !== 32'h3F00_0000) begin failures++; $display("FAIL basic_k: got %h expected %h", oKmp1, 32'h3F00_0000); end
    checks++;
    if (oErrormp1 !== 32'h3F40_0000) begin failures++; $display("FAIL basic_e: got %h expected %h", oErrormp1, 32'h3F40_0000); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [7] = '{32'h3E80_0000, 32'hC040_0000, 32'h0000_0000, 32'h3F00_0000,
                            32'hC000_0000, 32'hBF80_0000, 32'h0000_0001};
    logic [31:0] ve [7] = '{32'h3F80_0000, 32'h4080_0000, 32'h40A0_0000, 32'h0000_0000,
                            32'h3F80_0000, 32'h4040_0000, 32'h4000_0000};
    logic [31:0] xk [7] = '{32'hBE80_0000, 32'h3F40_0000, 32'h0000_0000, 32'h0000_0000,
                            32'h4000_0000, 32'h3EAA_AAAA, 32'h0000_0000};
    logic [31:0] xe [7] = '{32'h3F70_0000, 32'h3FE0_0000, 32'h40A0_0000, 32'h0000_0000,
                            32'hC040_0000, 32'h402A_AAAA, 32'h4000_0000};
    int n;
    for (int v = 0; v < 7; v++) begin
      start_run(va[v], ve[v]);
      wait_done(n);
      checks++;
      if (n !== 30) begin failures++; $display("FAIL vec%0d_latency: got %0d expected 30", v, n); end
      checks++;
      if (oKmp1 !== xk[v]) begin failures++; $display("FAIL vec%0d_k: got %h expected %h", v, oKmp1, xk[v]); end
      checks++;
      if (oErrormp1 !== xe[v]) begin failures++; $display("FAIL vec%0d_e: got %h expected %h", v, oErrormp1, xe[v]); end
    end
  endtask

  // Seven disabled edges inside DIV, inputs changed right after capture.
  task automatic test_stall_inputs();
    int n;
    start_run(32'hBF00_0000, 32'h3F80_0000);
    n = 0;
    while (n < 100) begin
      iEnable = !(n >= 6 && n < 13);
      @(posedge iClock);
      #1;
      n++;
      if (n == 1) begin
        iAlpham = 32'h3E80_0000;
        iErrorm = 32'h4080_0000;
      end
      if (oDone) break;
      @(negedge iClock);
    end
    iEnable = 1'b1;
    checks++;
    if (n !== 37) begin failures++; $display("FAIL stall_latency: got %0d expected 37", n); end
    checks++;
    if (oKmp1 !== 32'h3F00_0000) begin failures++; $display("FAIL stall_k: got %h expected %h", oKmp1, 32'h3F00_0000); end
    checks++;
    if (oErrormp1 !== 32'h3F40_0000) begin failures++; $display("FAIL stall_e: got %h expected %h", oErrormp1, 32'h3F40_0000); end
  endtask

  task automatic test_reset_abort();
    int n;
    start_run(32'hBF00_0000, 32'h3F80_0000);
    repeat (16) @(posedge iClock);
    @(negedge iClock);
    iReset = 1'b0;
    #1;
    checks++;
    if (oDone !== 1'b0 || oKmp1 !== 32'h0 || oErrormp1 !== 32'h0) begin
      failures++;
      $display("FAIL abort_reset: got done=%b k=%h e=%h expected 0/0/0", oDone, oKmp1, oErrormp1);
    end
    repeat (3) @(negedge iClock);
    iReset = 1'b1;
    wait_done(n);
    checks++;
    if (n !== 30) begin failures++; $display("FAIL abort_latency: got %0d expected 30", n); end
    checks++;
    if (oKmp1 !== 32'h3F00_0000) begin failures++; $display("FAIL abort_k: got %h expected %h", oKmp1, 32'h3F00_0000); end
    checks++;
    if (oErrormp1 !== 32'h3F40_0000) begin failures++; $display("FAIL abort_e: got %h expected %h", oErrormp1, 32'h3F40_0000); end
  endtask

  // Results hold after done, then an asynchronous reset clears them mid-cycle.
  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      iAlpham = $urandom;
      iErrorm = $urandom;
      @(posedge iClock);
      #1;
      checks++;
      if (oDone !== 1'b1 || oKmp1 !== 32'h3F00_0000 || oErrormp1 !== 32'h3F40_0000) begin
        failures++;
        $display("FAIL hold cycle %0d: got done=%b k=%h e=%h expected 1/3f000000/3f400000", i, oDone, oKmp1, oErrormp1);
      end
    end
    #2;
    iReset = 1'b0;
    #1;
    checks++;
    if (oKmp1 !== 32'h0) begin failures++; $display("FAIL async_reset_k: got %h expected %h", oKmp1, 32'h0); end
    checks++;
    if (oErrormp1 !== 32'h0) begin failures++; $display("FAIL async_reset_e: got %h expected %h", oErrormp1, 32'h0); end
    checks++;
    if (oDone !== 1'b0) begin failures++; $display("FAIL async_reset_done: got %b expected 0", oDone); end
    @(negedge iClock);
    iReset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_stall_inputs();
    test_reset_abort();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
